scan_sel_ctrl: RTL and testbench

- Sequential scan controller that sits directly upstream of the team's 2-to-4 enabled decoder.
- It generates the decoder's select pair (a, b) and enable, so that four digit/row lines are time-multiplexed.
- Each active line is held for a programmable dwell time, followed by a blanking gap to prevent ghosting.
- Masked lines are skipped.

---
 rtl/scan_sel_ctrl_pkg.sv | 21 ++
 rtl/scan_sel_ctrl_if.sv | 25 ++
 rtl/scan_next_sel.sv | 25 ++
 rtl/scan_sel_ctrl.sv | 108 ++++++++++
 tb/tb_scan_sel_ctrl.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/scan_sel_ctrl_pkg.sv
// Shared types and constants for the scan select controller.
package scan_sel_ctrl_pkg;

    localparam int IDX_W   = 2;
    localparam int N_LINES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Index of the lowest set bit of mask; 0 when mask is empty.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [N_LINES-1:0] mask);
        lowest_set = '0;
        for (int i = N_LINES - 1; i >= 0; i--) begin
            if (mask[i]) lowest_set = IDX_W'(i);
        end
    endfunction

endpackage

// File: rtl/scan_sel_ctrl_if.sv
// Control inputs and decoder-facing outputs of the scan select controller.
interface scan_sel_ctrl_if;
    import scan_sel_ctrl_pkg::*;

    logic               run;
    logic [N_LINES-1:0] line_mask;
    logic               sel_a;
    logic               sel_b;
    logic               dec_en;
    logic [IDX_W-1:0]   line_idx;
    logic               frame_tick;

    // Upstream side: drives run/mask and observes the scan outputs.
    modport master (
        output run, line_mask,
        input  sel_a, sel_b, dec_en, line_idx, frame_tick
    );

    // Controller side.
    modport slave (
        input  run, line_mask,
        output sel_a, sel_b, dec_en, line_idx, frame_tick
    );

endinterface

// File: rtl/scan_next_sel.sv
// Picks the next participating line after idx, wrapping to the lowest one.
module scan_next_sel
    import scan_sel_ctrl_pkg::*;
(
    input  logic [N_LINES-1:0] mask,
    input  logic [IDX_W-1:0]   idx,
    output logic [IDX_W-1:0]   nxt_idx,
    output logic               wrap
);

    // Scan downward so the lowest set bit strictly above idx wins.
    always_comb begin
        // NOTE: every output gets a default before any conditional update,
        // otherwise a path that leaves it unassigned infers a latch.
        nxt_idx = lowest_set(mask);
        wrap    = 1'b1;
        for (int i = N_LINES - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(idx))) begin
                nxt_idx = IDX_W'(i);
                wrap    = 1'b0;
            end
        end
    end

endmodule

// File: rtl/scan_sel_ctrl.sv
// Time-multiplexed line scanner feeding a 2-to-4 enabled decoder:
// each active line is enabled for DWELL cycles, then blanked for BLANK cycles.
module scan_sel_ctrl
    import scan_sel_ctrl_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int DWELL = 1000,
    parameter int BLANK = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    scan_sel_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] DWELL_M1 = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] BLANK_M1 = CNT_W'((BLANK > 0) ? BLANK - 1 : 0);

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic               en_q, en_n;
    logic               tick_q, tick_n;
    logic [IDX_W-1:0]   nxt_idx;
    logic               wrap;

    scan_next_sel u_next (
        .mask    (bus.line_mask),
        .idx     (idx),
        .nxt_idx (nxt_idx),
        .wrap    (wrap)
    );

    // Next-state logic: stop conditions first, then dwell/blank expiry.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        tick_n  = 1'b0;
        if (!bus.run || (bus.line_mask == '0)) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_n = ON;
                    idx_n   = lowest_set(bus.line_mask);
                    cnt_n   = DWELL_M1;
                end
                ON: begin
                    // A line dropped from the mask ends its dwell early.
                    if ((cnt == '0) || !bus.line_mask[idx]) begin
                        if (BLANK > 0) begin
                            state_n = GAP;
                            cnt_n   = BLANK_M1;
                        end else begin
                            idx_n   = nxt_idx;
                            tick_n  = wrap;
                            cnt_n   = DWELL_M1;
                        end
                    end else begin
                        cnt_n = cnt - CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        state_n = ON;
                        idx_n   = nxt_idx;
                        tick_n  = wrap;
                        cnt_n   = DWELL_M1;
                    end else begin
                        cnt_n = cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    assign en_n = (state_n == ON);

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            en_q   <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            idx    <= idx_n;
            en_q   <= en_n;
            tick_q <= tick_n;
        end
    end

    assign bus.sel_a      = idx[1];
    assign bus.sel_b      = idx[0];
    assign bus.line_idx   = idx;
    assign bus.dec_en     = en_q;
    assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_scan_sel_ctrl.sv
// Directed scoreboard bench: dut uses DWELL=3/BLANK=1, dut_z uses DWELL=3/BLANK=0.
module tb_scan_sel_ctrl;
    import scan_sel_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    scan_sel_ctrl_if bus_a ();
    scan_sel_ctrl_if bus_z ();

    scan_sel_ctrl #(.CNT_W(16), .DWELL(3), .BLANK(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    scan_sel_ctrl #(.CNT_W(16), .DWELL(3), .BLANK(0)) dut_z (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_z.slave)
    );

    typedef struct {
        bit         which;    // 0: dut, 1: dut_z
        logic       en;
        logic [1:0] idx;
        bit         chk_idx;
        logic       tick;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(string tag, logic [3:0] obs, logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(bit which, logic en, logic [1:0] idx, logic tick, string tag,
                        bit chk_idx = 1'b1);
        exp_t e;
        e.which   = which;
        e.en      = en;
        e.idx     = idx;
        e.chk_idx = chk_idx;
        e.tick    = tick;
        e.tag     = tag;
        sb.push_back(e);
    endtask

    // Pop one expectation and compare it with the outputs after the edge.
    task automatic compare_one();
        exp_t       e;
        logic       en, tick, sa, sb_bit;
        logic [1:0] idx;
        logic [3:0] oh_obs, oh_exp;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = sb.pop_front();
        if (e.which) begin
            en = bus_z.dec_en; tick = bus_z.frame_tick; idx = bus_z.line_idx;
            sa = bus_z.sel_a;  sb_bit = bus_z.sel_b;
        end else begin
            en = bus_a.dec_en; tick = bus_a.frame_tick; idx = bus_a.line_idx;
            sa = bus_a.sel_a;  sb_bit = bus_a.sel_b;
        end
        check({e.tag, ".dec_en"}, {3'b0, en}, {3'b0, e.en});
        check({e.tag, ".frame_tick"}, {3'b0, tick}, {3'b0, e.tick});
        if (e.chk_idx) begin
            check({e.tag, ".line_idx"}, {2'b0, idx}, {2'b0, e.idx});
            check({e.tag, ".sel"}, {2'b0, sa, sb_bit}, {2'b0, e.idx});
        end
        if (e.chk_idx || !e.en) begin
            oh_obs = en ? (4'b1000 >> {sa, sb_bit}) : 4'b0000;
            oh_exp = e.en ? (4'b1000 >> e.idx) : 4'b0000;
            check({e.tag, ".onehot"}, oh_obs, oh_exp);
        end
    endtask

    task automatic run_cycles(int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            compare_one();
        end
    endtask

    task automatic step(bit which, logic en, logic [1:0] idx, logic tick, string tag,
                        bit chk_idx = 1'b1);
        push(which, en, idx, tick, tag, chk_idx);
        run_cycles(1);
    endtask

    // One full line slot: dwell cycles enabled, then blank cycles disabled.
    task automatic line(bit which, logic [1:0] idx, logic tick_first, int dwell,
                        int blank, string tag);
        for (int k = 0; k < dwell; k++)
            push(which, 1'b1, idx, (k == 0) ? tick_first : 1'b0, tag);
        for (int k = 0; k < blank; k++)
            push(which, 1'b0, idx, 1'b0, tag);
        run_cycles(dwell + blank);
    endtask

    task automatic la(logic [1:0] idx, logic tick_first, string tag);
        line(1'b0, idx, tick_first, 3, 1, tag);
    endtask

    task automatic lz(logic [1:0] idx, logic tick_first, string tag);
        line(1'b1, idx, tick_first, 3, 0, tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n           = 1'b0;
        bus_a.run       = 1'b1;
        bus_a.line_mask = 4'b1111;
        bus_z.run       = 1'b0;
        bus_z.line_mask = 4'b1111;

        // Reset held with run active.
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 2'd0, 1'b0, "reset");
        rst_n = 1'b1;

        // Full scan, two frames: frame_tick only when idx wraps to 0.
        la(0, 0, "full0"); la(1, 0, "full1"); la(2, 0, "full2"); la(3, 0, "full3");
        la(0, 1, "full0w"); la(1, 0, "full1"); la(2, 0, "full2"); la(3, 0, "full3");
        la(0, 1, "full0w");

        // run dropped in the 2nd ON cycle of idx 1.
        step(1'b0, 1'b1, 2'd1, 1'b0, "run_on1");
        step(1'b0, 1'b1, 2'd1, 1'b0, "run_on2");
        bus_a.run = 1'b0;
        step(1'b0, 1'b0, 2'd1, 1'b0, "run_idle");
        step(1'b0, 1'b0, 2'd1, 1'b0, "run_idle");
        bus_a.run = 1'b1;
        la(0, 0, "run_restart");

        // Current line's mask bit cleared mid-dwell.
        la(1, 0, "clr1");
        step(1'b0, 1'b1, 2'd2, 1'b0, "clr_on2");
        bus_a.line_mask = 4'b1011;
        step(1'b0, 1'b0, 2'd2, 1'b0, "clr_gap");
        la(3, 0, "clr3"); la(0, 1, "clr0w"); la(1, 0, "clr1b"); la(3, 0, "clr3b");

        // Sparse mask: lines 1 and 3 only.
        bus_a.line_mask = 4'b1010;
        la(1, 1, "sparse1"); la(3, 0, "sparse3"); la(1, 1, "sparse1"); la(3, 0, "sparse3");

        // Single active line wraps onto itself every period.
        bus_a.line_mask = 4'b0100;
        la(2, 1, "single"); la(2, 1, "single"); la(2, 1, "single");

        // Empty mask forces IDLE; restoring it restarts from line 0.
        bus_a.line_mask = 4'b0000;
        step(1'b0, 1'b0, 2'd0, 1'b0, "mask0", 1'b0);
        step(1'b0, 1'b0, 2'd0, 1'b0, "mask0", 1'b0);
        bus_a.line_mask = 4'b1111;
        la(0, 0, "mask_restart");

        // Reset asserted during GAP.
        push(1'b0, 1'b1, 2'd1, 1'b0, "rstgap_on");
        push(1'b0, 1'b1, 2'd1, 1'b0, "rstgap_on");
        push(1'b0, 1'b1, 2'd1, 1'b0, "rstgap_on");
        push(1'b0, 1'b0, 2'd1, 1'b0, "rstgap_gap");
        run_cycles(4);
        rst_n = 1'b0;
        step(1'b0, 1'b0, 2'd0, 1'b0, "rstgap_rst");
        rst_n = 1'b1;
        la(0, 0, "rstgap_after");

        // BLANK=0 instance: enable stays high, index advances every 3 cycles.
        bus_a.run = 1'b0;
        bus_z.run = 1'b1;
        lz(0, 0, "b0_0"); lz(1, 0, "b0_1"); lz(2, 0, "b0_2"); lz(3, 0, "b0_3");
        lz(0, 1, "b0_0w");
        step(1'b1, 1'b1, 2'd1, 1'b0, "b0_clr_on1");
        bus_z.line_mask = 4'b1101;
        step(1'b1, 1'b1, 2'd2, 1'b0, "b0_clr_on2");
        step(1'b1, 1'b1, 2'd2, 1'b0, "b0_clr_on2");
        step(1'b1, 1'b1, 2'd2, 1'b0, "b0_clr_on2");
        step(1'b1, 1'b1, 2'd3, 1'b0, "b0_clr_on3");
        bus_z.run = 1'b0;
        step(1'b1, 1'b0, 2'd3, 1'b0, "b0_stop");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
